// File: rtl/e_mdu_param_if.sv
// Handshake/bus bundle between the EX stage and the multiply/divide unit.
// The master is the pipeline side; the slave is the MDU.
interface e_mdu_param_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             start;
  logic             done;

  modport master (
    output req, op, a, b,
    input  result, busy, start, done
  );

  modport slave (
    input  req, op, a, b,
    output result, busy, start, done
  );
endinterface

// File: rtl/e_mdu_param.sv
// Multiply/divide unit with configurable latency and atomic HI/LO commit.
// The result is computed at issue and held in temporaries until the final busy cycle.
module e_mdu_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input logic           clk,
  input logic           reset,
  e_mdu_param_if.slave  bus
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;
  localparam logic [3:0] OpMadd  = 4'd9;
  localparam logic [3:0] OpMaddu = 4'd10;

  localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  localparam logic [WIDTH-1:0] One     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);
  localparam logic [CntW-1:0]  CntMul  = CntW'(MULT_LAT);
  localparam logic [CntW-1:0]  CntDiv  = CntW'(DIV_LAT);

  typedef enum logic {StIdle, StRun} state_t;

  state_t           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_hi, w_hi_d;
  logic [WIDTH-1:0] r_lo, w_lo_d;
  logic [WIDTH-1:0] r_hi_t, w_hi_t_d;
  logic [WIDTH-1:0] r_lo_t, w_lo_t_d;

  logic             w_long;
  logic             w_is_div;
  logic             w_start;
  logic             w_done;

  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;

  logic             w_signed_div;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_dvd;
  logic [WIDTH-1:0] w_dvs;
  logic [WIDTH-1:0] w_dvs_safe;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_r_mag;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic             w_div_zero;
  logic             w_div_ovf;

  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_long = (bus.op == OpMult) || (bus.op == OpMultu) || (bus.op == OpDiv) ||
                  (bus.op == OpDivu) || (bus.op == OpMadd)  || (bus.op == OpMaddu);
  assign w_is_div = (bus.op == OpDiv) || (bus.op == OpDivu);
  assign w_start  = w_long && (r_state == StIdle) && !bus.req;

  assign w_prod_s = $signed({{WIDTH{bus.a[WIDTH-1]}}, bus.a}) *
                    $signed({{WIDTH{bus.b[WIDTH-1]}}, bus.b});
  assign w_prod_u = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

  // Signed divide runs on magnitudes so the core divider is always unsigned.
  assign w_signed_div = (bus.op == OpDiv);
  assign w_a_neg      = w_signed_div && bus.a[WIDTH-1];
  assign w_b_neg      = w_signed_div && bus.b[WIDTH-1];
  assign w_dvd        = w_a_neg ? (~bus.a + One) : bus.a;
  assign w_dvs        = w_b_neg ? (~bus.b + One) : bus.b;
  assign w_div_zero   = (bus.b == '0);
  assign w_dvs_safe   = w_div_zero ? One : w_dvs;
  assign w_q_mag      = w_dvd / w_dvs_safe;
  assign w_r_mag      = w_dvd % w_dvs_safe;
  assign w_quo        = (w_a_neg ^ w_b_neg) ? (~w_q_mag + One) : w_q_mag;
  assign w_rem        = w_a_neg ? (~w_r_mag + One) : w_r_mag;
  assign w_div_ovf    = w_signed_div && (bus.a == MostNeg) && (bus.b == '1);

  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    case (bus.op)
      OpMult:  {w_res_hi, w_res_lo} = w_prod_s;
      OpMultu: {w_res_hi, w_res_lo} = w_prod_u;
      OpMadd:  {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_prod_s;
      OpMaddu: {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_prod_u;
      OpDiv, OpDivu: begin
        if (w_div_zero) begin
          w_res_hi = bus.a;
          w_res_lo = '1;
        end else if (w_div_ovf) begin
          w_res_hi = '0;
          w_res_lo = bus.a;
        end else begin
          w_res_hi = w_rem;
          w_res_lo = w_quo;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_hi_d    = r_hi;
    w_lo_d    = r_lo;
    w_hi_t_d  = r_hi_t;
    w_lo_t_d  = r_lo_t;
    w_done    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_hi_t_d  = w_res_hi;
          w_lo_t_d  = w_res_lo;
          w_cnt_d   = w_is_div ? CntDiv : CntMul;
          w_state_d = StRun;
        end else if (!bus.req && (bus.op == OpMthi)) begin
          w_hi_d = bus.a;
        end else if (!bus.req && (bus.op == OpMtlo)) begin
          w_lo_d = bus.a;
        end
      end
      StRun: begin
        w_cnt_d = r_cnt - CntOne;
        if (r_cnt == CntOne) begin
          w_done    = 1'b1;
          w_hi_d    = r_hi_t;
          w_lo_d    = r_lo_t;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_hi_t  <= '0;
      r_lo_t  <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_hi    <= w_hi_d;
      r_lo    <= w_lo_d;
      r_hi_t  <= w_hi_t_d;
      r_lo_t  <= w_lo_t_d;
    end
  end

  assign bus.busy   = (r_state == StRun);
  assign bus.start  = w_start;
  assign bus.done   = w_done;
  assign bus.result = (bus.op == OpMfhi) ? r_hi :
                      (bus.op == OpMflo) ? r_lo : '0;

endmodule

// File: tb/tb_e_mdu_param.sv
// Bench for e_mdu_param: directed vector table, hand-written hazard/reset sequences,
// and randomized ops checked against a 64-bit arithmetic model of HI/LO.
module tb_e_mdu_param;

  localparam int unsigned W        = 32;
  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [63:0] m_acc;

  e_mdu_param_if #(.WIDTH(W)) bus ();

  e_mdu_param #(.WIDTH(W), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return ua * ub;
      4'd9: return acc + 64'(sa * sb);
      4'd10: return acc + ua * ub;
      4'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return acc;
    endcase
  endfunction

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    bus.op = 4'd5;
    #1;
    h = bus.result;
    bus.op = 4'd6;
    #1;
    l = bus.result;
    bus.op = 4'd0;
    #1;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    bus.op  = op;
    bus.a   = v;
    bus.req = 1'b0;
    tick();
    bus.op = 4'd0;
  endtask

  // Issues a long op and follows it to completion; junk drives ignored ops while busy.
  task automatic run_long(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input bit junk);
    int lat, n;
    bit done_bad;
    lat = (op == 4'd3 || op == 4'd4) ? DIV_LAT : MULT_LAT;
    bus.op  = op;
    bus.a   = av;
    bus.b   = bv;
    bus.req = 1'b0;
    #1;
    check("start_on_issue", bus.start, 1);
    tick();
    bus.op = 4'd0;
    n = 0;
    done_bad = 0;
    while (bus.busy && n < 200) begin
      n++;
      if (bus.done !== (n == lat)) done_bad = 1;
      if (junk) begin
        bus.op  = 4'($urandom_range(0, 15));
        bus.a   = $urandom;
        bus.b   = $urandom;
        bus.req = 1'($urandom_range(0, 1));
        #1;
        check("start_while_busy", bus.start, 0);
        if (bus.op == 4'd5) check("mfhi_while_busy", bus.result, m_acc[63:32]);
        if (bus.op == 4'd6) check("mflo_while_busy", bus.result, m_acc[31:0]);
      end
      tick();
      bus.op  = 4'd0;
      bus.req = 1'b0;
    end
    check("busy_cycles", n, lat);
    check("done_only_last", done_bad, 0);
  endtask

  initial begin
    vec_t vecs[9];
    logic [31:0] h, l;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    bit          rq, long_op, bad;
    int          n;

    vecs[0] = '{32'h0, 32'h0, 4'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{32'h0, 32'h0, 4'd2, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1};
    vecs[2] = '{32'h0, 32'h0, 4'd4, 32'd100, 32'd7, 32'd2, 32'd14};
    vecs[3] = '{32'h0, 32'h0, 4'd3, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2};
    vecs[4] = '{32'h0, 32'h0, 4'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF};
    vecs[5] = '{32'h0, 32'h0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
    vecs[6] = '{32'h0, 32'hFFFF_FFFF, 4'd10, 32'd1, 32'd1, 32'd1, 32'd0};
    vecs[7] = '{32'h1, 32'h0, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF};
    vecs[8] = '{32'h0, 32'h0, 4'd4, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF};

    bus.req = 1'b0;
    bus.op  = 4'd0;
    bus.a   = '0;
    bus.b   = '0;
    reset   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_start_idle_op", bus.start, 0);
    check("reset_result_none", bus.result, 0);
    read_hilo(h, l);
    check("reset_hilo", {h, l}, 64'h0);
    m_acc = '0;

    foreach (vecs[i]) begin
      mt(4'd7, vecs[i].pre_hi);
      mt(4'd8, vecs[i].pre_lo);
      read_hilo(h, l);
      check("mt_readback", {h, l}, {vecs[i].pre_hi, vecs[i].pre_lo});
      run_long(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      read_hilo(h, l);
      check("vec_hi", h, vecs[i].exp_hi);
      check("vec_lo", l, vecs[i].exp_lo);
    end

    // req blocks both long ops and moves.
    mt(4'd7, 32'h1111_2222);
    mt(4'd8, 32'h3333_4444);
    bus.req = 1'b1;
    bus.op  = 4'd1;
    bus.a   = 32'd3;
    bus.b   = 32'd3;
    #1;
    check("req_start", bus.start, 0);
    tick();
    check("req_busy", bus.busy, 0);
    bus.op = 4'd7;
    tick();
    bus.op  = 4'd0;
    bus.req = 1'b0;
    read_hilo(h, l);
    check("req_hilo_kept", {h, l}, 64'h1111_2222_3333_4444);

    // Second mult presented while busy must be ignored.
    bus.op = 4'd1;
    bus.a  = 32'd3;
    bus.b  = 32'd4;
    #1;
    check("first_start", bus.start, 1);
    tick();
    bus.a = 32'd7;
    bus.b = 32'd9;
    #1;
    check("second_start", bus.start, 0);
    tick();
    bus.op = 4'd0;
    n = 0;
    while (bus.busy && n < 50) begin
      n++;
      tick();
    end
    check("first_busy_rest", n, MULT_LAT - 1);
    read_hilo(h, l);
    check("only_first_commits", {h, l}, 64'd12);

    // Back-to-back issue in the first idle cycle.
    run_long(4'd2, 32'd6, 32'd7, 1'b0);
    run_long(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    read_hilo(h, l);
    check("back_to_back", {h, l}, 64'hFFFF_FFFF_FFFF_FFFA);

    // Reset in the third busy cycle discards the pending commit.
    mt(4'd7, 32'hAAAA);
    mt(4'd8, 32'h5555);
    bus.op = 4'd1;
    bus.a  = 32'd5;
    bus.b  = 32'd5;
    tick();
    bus.op = 4'd0;
    tick();
    tick();
    check("third_busy_cycle", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid_busy", bus.busy, 0);
    read_hilo(h, l);
    check("reset_mid_hilo", {h, l}, 64'h0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1;
      tick();
    end
    check("no_done_after_reset", bad, 0);
    read_hilo(h, l);
    check("no_commit_after_reset", {h, l}, 64'h0);
    m_acc = '0;

    // Randomized ops against the arithmetic model.
    for (int it = 0; it < 80; it++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 15) == 0) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      rq = ($urandom_range(0, 7) == 0);
      long_op = (rop inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10});
      bus.op  = rop;
      bus.a   = ra;
      bus.b   = rb;
      bus.req = rq;
      #1;
      check("rand_start", bus.start, long_op && !rq);
      if (rop == 4'd5) check("rand_mfhi", bus.result, m_acc[63:32]);
      if (rop == 4'd6) check("rand_mflo", bus.result, m_acc[31:0]);
      if (long_op && !rq) begin
        run_long(rop, ra, rb, 1'b1);
        m_acc = model(rop, ra, rb, m_acc);
      end else begin
        tick();
        if (!rq && rop == 4'd7) m_acc[63:32] = ra;
        if (!rq && rop == 4'd8) m_acc[31:0]  = ra;
        bus.op  = 4'd0;
        bus.req = 1'b0;
        check("rand_idle_busy", bus.busy, 0);
      end
      read_hilo(h, l);
      check("rand_hilo", {h, l}, m_acc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
